vga_timing: RTL and testbench

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_pkg.sv | 20 ++
 rtl/vga_timing_if.sv | 22 ++
 rtl/vga_timing.sv | 96 +++++++++
 tb/tb_vga_timing.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared SVGA 800x600@60 timing constants and counter type
package vga_pkg;

    localparam int CNT_W = 11;

    localparam int H_VISIBLE = 800;
    localparam int H_FP      = 40;
    localparam int H_SYNC    = 128;
    localparam int H_BP      = 88;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int V_VISIBLE = 600;
    localparam int V_FP      = 1;
    localparam int V_SYNC    = 4;
    localparam int V_BP      = 23;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/vga_timing_if.sv
// rtl/vga_timing_if.sv - raster position and sync/blank bundle
interface vga_timing_if;
    import vga_pkg::*;

    cnt_t hcount;
    cnt_t vcount;
    logic hsync;
    logic vsync;
    logic hblnk;
    logic vblnk;
    logic frame_start;

    // The timing generator drives the raster; drawing stages consume it.
    modport master (
        output hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start
    );

    modport slave (
        input  hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start
    );

endinterface

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - pixel/line counters with registered sync and blank decode
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int H_FP      = vga_pkg::H_FP,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BP      = vga_pkg::H_BP,
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int V_FP      = vga_pkg::V_FP,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BP      = vga_pkg::V_BP
) (
    input  logic            pclk,
    input  logic            rst,
    vga_timing_if.master    vga
);

    localparam cnt_t H_LAST   = cnt_t'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam cnt_t V_LAST   = cnt_t'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
    localparam cnt_t HB_START = cnt_t'(H_VISIBLE);
    localparam cnt_t HS_START = cnt_t'(H_VISIBLE + H_FP);
    localparam cnt_t HS_END   = cnt_t'(H_VISIBLE + H_FP + H_SYNC);
    localparam cnt_t VB_START = cnt_t'(V_VISIBLE);
    localparam cnt_t VS_START = cnt_t'(V_VISIBLE + V_FP);
    localparam cnt_t VS_END   = cnt_t'(V_VISIBLE + V_FP + V_SYNC);

    cnt_t hcount_q, hcount_d;
    cnt_t vcount_q, vcount_d;
    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic hblnk_q, hblnk_d;
    logic vblnk_q, vblnk_d;
    logic frame_start_q, frame_start_d;

    // Next raster position; frame_start marks entry to (0,0) via the frame wrap only.
    always_comb begin
        hcount_d      = hcount_q + cnt_t'(1);
        vcount_d      = vcount_q;
        frame_start_d = 1'b0;
        if (hcount_q == H_LAST) begin
            hcount_d = '0;
            if (vcount_q == V_LAST) begin
                vcount_d      = '0;
                frame_start_d = 1'b1;
            end else begin
                vcount_d = vcount_q + cnt_t'(1);
            end
        end
    end

    // Decode from the next counts so the registered syncs line up with the counters.
    always_comb begin
        hblnk_d = (hcount_d >= HB_START);
        hsync_d = (hcount_d >= HS_START) && (hcount_d < HS_END);
        vblnk_d = (vcount_d >= VB_START);
        vsync_d = (vcount_d >= VS_START) && (vcount_d < VS_END);
    end

    // Counter register.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    // Registered sync/blank/frame decode.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblnk_q       <= hblnk_d;
            vblnk_q       <= vblnk_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga.hcount      = hcount_q;
    assign vga.vcount      = vcount_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.hblnk       = hblnk_q;
    assign vga.vblnk       = vblnk_q;
    assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - directed bench: full-size line timing plus a shrunken raster for frame wraps
`timescale 1ns/1ps
module tb_vga_timing;

    logic pclk;
    logic rst;

    vga_timing_if dut_if ();
    vga_timing_if sml_if ();

    vga_timing dut (
        .pclk (pclk),
        .rst  (rst),
        .vga  (dut_if)
    );

    // Small raster: 15 pixels x 8 lines, 120 cycles per frame.
    // hblnk h>=8, hsync h in 10..12, vblnk v>=4, vsync v in 5..6.
    vga_timing #(
        .H_VISIBLE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_VISIBLE (4), .V_FP (1), .V_SYNC (2), .V_BP (1)
    ) sml (
        .pclk (pclk),
        .rst  (rst),
        .vga  (sml_if)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;
    int n = 0;
    int hs_high = 0;
    int fs_pulses = 0;
    int first_hs = -1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, n);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_h"},   dut_if.hcount, 0);
        check({tag, "_v"},   dut_if.vcount, 0);
        check({tag, "_hs"},  dut_if.hsync, 0);
        check({tag, "_vs"},  dut_if.vsync, 0);
        check({tag, "_hb"},  dut_if.hblnk, 0);
        check({tag, "_vb"},  dut_if.vblnk, 0);
        check({tag, "_fs"},  dut_if.frame_start, 0);
        check({tag, "_sh"},  sml_if.hcount, 0);
        check({tag, "_sv"},  sml_if.vcount, 0);
        check({tag, "_shs"}, sml_if.hsync, 0);
        check({tag, "_svs"}, sml_if.vsync, 0);
        check({tag, "_shb"}, sml_if.hblnk, 0);
        check({tag, "_svb"}, sml_if.vblnk, 0);
        check({tag, "_sfs"}, sml_if.frame_start, 0);
    endtask

    // Expected raster derived from the number of edges since reset release.
    task automatic check_model();
        int h, v, sh, sv;
        h  = n % 1056;
        v  = (n / 1056) % 628;
        sh = n % 15;
        sv = (n / 15) % 8;
        check("hcount", dut_if.hcount, h);
        check("vcount", dut_if.vcount, v);
        check("hsync",  dut_if.hsync, (h >= 840 && h < 968) ? 1 : 0);
        check("hblnk",  dut_if.hblnk, (h >= 800) ? 1 : 0);
        check("vsync",  dut_if.vsync, (v >= 601 && v < 605) ? 1 : 0);
        check("vblnk",  dut_if.vblnk, (v >= 600) ? 1 : 0);
        check("frame_start", dut_if.frame_start, (n > 0 && n % 663168 == 0) ? 1 : 0);
        check("s_hcount", sml_if.hcount, sh);
        check("s_vcount", sml_if.vcount, sv);
        check("s_hsync",  sml_if.hsync, (sh >= 10 && sh < 13) ? 1 : 0);
        check("s_hblnk",  sml_if.hblnk, (sh >= 8) ? 1 : 0);
        check("s_vsync",  sml_if.vsync, (sv >= 5 && sv < 7) ? 1 : 0);
        check("s_vblnk",  sml_if.vblnk, (sv >= 4) ? 1 : 0);
        check("s_frame_start", sml_if.frame_start, (n > 0 && n % 120 == 0) ? 1 : 0);
    endtask

    task automatic run_cycles(input int count);
        for (int i = 0; i < count; i++) begin
            @(posedge pclk);
            n++;
            @(negedge pclk);
            check_model();
            if (dut_if.hsync === 1'b1) begin
                hs_high++;
                if (first_hs < 0) first_hs = n;
            end
            if (sml_if.frame_start === 1'b1) fs_pulses++;
        end
    endtask

    // Assert reset between edges, check outputs cleared at once, hold, release on a falling edge.
    task automatic async_reset(input string tag, input int hold);
        #2 rst = 1'b1;
        #1 check_reset(tag);
        for (int i = 0; i < hold; i++) begin
            @(negedge pclk);
            check_reset({tag, "_hold"});
        end
        rst = 1'b0;
        n = 0;
        hs_high = 0;
        fs_pulses = 0;
        first_hs = -1;
    endtask

    initial begin
        rst = 1'b0;
        #1 rst = 1'b1;
        #1 check_reset("por");
        for (int i = 0; i < 5; i++) begin
            @(negedge pclk);
            check_reset("por_hold");
        end
        rst = 1'b0;
        n = 0;

        // Two full lines then stop mid-line at hcount 500.
        run_cycles(1);
        check("first_edge_h", dut_if.hcount, 1);
        check("first_edge_v", dut_if.vcount, 0);
        run_cycles(2611);
        check("hsync_width_2lines", hs_high, 256);
        check("first_hsync_at", first_hs, 840);
        check("sml_frames", fs_pulses, 21);
        check("mid_line_h", dut_if.hcount, 500);
        check("mid_line_v", dut_if.vcount, 2);

        // Reset in the middle of a line / mid small frame.
        async_reset("rst_mid", 5);
        run_cycles(1);
        check("restart_h", dut_if.hcount, 1);
        check("restart_v", dut_if.vcount, 0);
        run_cycles(899);
        check("hsync_active_900", dut_if.hsync, 1);

        // Reset while hsync is high; hsync must not return before hcount 840.
        async_reset("rst_hsync", 3);
        run_cycles(1200);
        check("hsync_return_at", first_hs, 840);
        check("hsync_width_after", hs_high, 128);
        check("sml_frames_after", fs_pulses, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
